// File: rtl/frog_io_pkg.sv
// Shared types and timing constants for the Frog_CPU button path.
// Holds the conditioner FSM states, board timing and bench timing.
package frog_io_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    HOLD_WAIT,
    REPEAT
  } btn_state_t;

  // 50 MHz board timing: 10 ms debounce, 0.5 s delay, 0.1 s period.
  localparam int DEF_DEBOUNCE = 500000;
  localparam int DEF_DELAY    = 25000000;
  localparam int DEF_PERIOD   = 5000000;
  localparam int DEF_CNT_W    = 25;

  // Short timing so a simulation covers every path in a few cycles.
  localparam int SIM_DEBOUNCE = 4;
  localparam int SIM_DELAY    = 10;
  localparam int SIM_PERIOD   = 3;
  localparam int SIM_CNT_W    = 4;

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser plus stable-count debouncer.
// Ports: clk, rst, button in; level, rise, fall out.
module debounce_filter
  import frog_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] D_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] dcnt;
  logic             hit;

  // Strobes are combinational so the FSM acts on the
  // same edge that flips level.
  assign hit  = (s2 != level) && (dcnt == D_LAST);
  assign rise = hit & ~level;
  assign fall = hit & level;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      dcnt  <= '0;
    end else begin
      s1 <= button;
      s2 <= s1;
      if (s2 == level) begin
        dcnt <= '0;
      end else if (dcnt == D_LAST) begin
        level <= ~level;
        dcnt  <= '0;
      end else begin
        dcnt <= dcnt + ONE;
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Debounced single-step pulse generator with auto-repeat.
// Ports: clk, rst, button in; step, level, repeating out.
module button_conditioner
  import frog_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = DEF_DELAY,
  parameter int REPEAT_PERIOD   = DEF_PERIOD,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic step,
  output logic level,
  output logic repeating
);

  localparam bit REP_ON = (REPEAT_EN != 0);
  localparam logic [CNT_W-1:0] DLY_LAST =
    CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST =
    CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  btn_state_t       state;
  logic [CNT_W-1:0] hcnt;
  logic             rise;
  logic             fall;

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_filter (
    .clk   (clk),
    .rst   (rst),
    .button(button),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RELEASED;
      hcnt      <= '0;
      step      <= 1'b0;
      repeating <= 1'b0;
    end else begin
      step <= 1'b0;
      // A release beats any repeat pulse due on the same edge.
      if (fall) begin
        state     <= RELEASED;
        hcnt      <= '0;
        repeating <= 1'b0;
      end else begin
        unique case (state)
          RELEASED: begin
            if (rise) begin
              step <= 1'b1;
              hcnt <= '0;
              // Without repeat, REPEAT is a parked hold state.
              state <= REP_ON ? HOLD_WAIT : REPEAT;
            end
          end
          HOLD_WAIT: begin
            if (hcnt == DLY_LAST) begin
              step      <= 1'b1;
              hcnt      <= '0;
              state     <= REPEAT;
              repeating <= REP_ON;
            end else begin
              hcnt <= hcnt + ONE;
            end
          end
          REPEAT: begin
            if (REP_ON) begin
              if (hcnt == PER_LAST) begin
                step <= 1'b1;
                hcnt <= '0;
              end else begin
                hcnt <= hcnt + ONE;
              end
            end
          end
          default: begin
            state <= RELEASED;
            hcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner.
// Step edges are queued at stimulus time and popped on each pulse.
module tb_button_conditioner;
  import frog_io_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, button, rst_nr, button_nr;
  logic step, level, repeating;
  logic step_nr, level_nr, repeating_nr;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int sb[$];
  int sb_nr[$];

  button_conditioner #(
    .DEBOUNCE_CYCLES(SIM_DEBOUNCE),
    .REPEAT_EN      (1),
    .REPEAT_DELAY   (SIM_DELAY),
    .REPEAT_PERIOD  (SIM_PERIOD),
    .CNT_W          (SIM_CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .button   (button),
    .step     (step),
    .level    (level),
    .repeating(repeating)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(SIM_DEBOUNCE),
    .REPEAT_EN      (0),
    .REPEAT_DELAY   (SIM_DELAY),
    .REPEAT_PERIOD  (SIM_PERIOD),
    .CNT_W          (SIM_CNT_W)
  ) dut_nr (
    .clk      (clk),
    .rst      (rst_nr),
    .button   (button_nr),
    .step     (step_nr),
    .level    (level_nr),
    .repeating(repeating_nr)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @cyc %0d",
               tag, $signed(got), $signed(exp), cyc);
    end
  endtask

  // Every pulse must match the next queued edge; stray
  // pulses compare against an impossible edge.
  always @(negedge clk) begin
    if (step === 1'b1) begin
      if (sb.size() == 0) check("step_extra", cyc, -1);
      else check("step_edge", cyc, sb.pop_front());
    end
    if (step_nr === 1'b1) begin
      if (sb_nr.size() == 0) check("nr_extra", cyc, -1);
      else check("nr_edge", cyc, sb_nr.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic at_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
    #1;
  endtask

  int t0;

  initial begin
    rst       = 1'b1;
    button    = 1'b0;
    rst_nr    = 1'b1;
    button_nr = 1'b0;
    tick(2);
    check("rst_step", step, 0);
    check("rst_level", level, 0);
    check("rst_rep", repeating, 0);

    // Reset held with button pressed, then clean hold.
    button = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rsthold_step", step, 0);
      check("rsthold_level", level, 0);
      check("rsthold_rep", repeating, 0);
    end
    rst = 1'b0;
    t0 = cyc + 1;
    sb.push_back(t0 + 5);
    sb.push_back(t0 + 15);
    sb.push_back(t0 + 18);
    sb.push_back(t0 + 21);
    sb.push_back(t0 + 24);
    at_edge(t0 + 4);
    check("hold_lvl_pre", level, 0);
    at_edge(t0 + 5);
    check("hold_lvl_up", level, 1);
    at_edge(t0 + 14);
    check("hold_rep_pre", repeating, 0);
    at_edge(t0 + 15);
    check("hold_rep_up", repeating, 1);
    // Release lands on edge 27, same as a repeat slot.
    at_edge(t0 + 21);
    button = 1'b0;
    at_edge(t0 + 26);
    check("coinc_lvl_pre", level, 1);
    at_edge(t0 + 27);
    check("coinc_lvl_dn", level, 0);
    check("coinc_rep_dn", repeating, 0);
    tick(8);

    // Release with first low sample at edge 16.
    button = 1'b1;
    t0 = cyc + 1;
    sb.push_back(t0 + 5);
    sb.push_back(t0 + 15);
    sb.push_back(t0 + 18);
    at_edge(t0 + 15);
    button = 1'b0;
    at_edge(t0 + 20);
    check("rel_lvl_pre", level, 1);
    check("rel_rep_pre", repeating, 1);
    at_edge(t0 + 21);
    check("rel_lvl_dn", level, 0);
    check("rel_rep_dn", repeating, 0);
    tick(10);

    // Bounce shorter than the window.
    for (int i = 0; i < 20; i++) begin
      button = ((i / 2) % 2) == 0;
      tick(1);
      check("bounce_lvl", level, 0);
    end
    button = 1'b0;
    tick(10);
    check("bounce_lvl_end", level, 0);

    // Reset pulse in the middle of a hold.
    button = 1'b1;
    t0 = cyc + 1;
    sb.push_back(t0 + 5);
    at_edge(t0 + 12);
    check("mid_lvl_pre", level, 1);
    rst = 1'b1;
    at_edge(t0 + 13);
    check("mid_step", step, 0);
    check("mid_lvl", level, 0);
    check("mid_rep", repeating, 0);
    rst = 1'b0;
    t0 = cyc + 1;
    sb.push_back(t0 + 5);
    sb.push_back(t0 + 15);
    sb.push_back(t0 + 18);
    at_edge(t0 + 4);
    check("mid_relvl_pre", level, 0);
    at_edge(t0 + 5);
    check("mid_relvl_up", level, 1);
    at_edge(t0 + 15);
    button = 1'b0;
    at_edge(t0 + 21);
    check("mid_rel_dn", level, 0);
    tick(10);

    // No-repeat instance held for 50 cycles.
    rst_nr    = 1'b0;
    button_nr = 1'b1;
    t0 = cyc + 1;
    sb_nr.push_back(t0 + 5);
    at_edge(t0 + 20);
    check("nr_lvl", level_nr, 1);
    check("nr_rep", repeating_nr, 0);
    at_edge(t0 + 49);
    button_nr = 1'b0;
    tick(10);
    check("nr_lvl_dn", level_nr, 0);

    tick(5);
    check("sb_left", sb.size(), 0);
    check("sb_nr_left", sb_nr.size(), 0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions the raw push-button that drives Frog_CPU's single-step input. It synchronises the asynchronous pin, debounces it, and emits exactly one-cycle `step` pulses, with optional auto-repeat while the button is held. The block sits between the board button pin and Frog_CPU's `button` input, in the same clock domain as Frog_CPU and Segment7.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a level change (10 ms at 50 MHz); must be ≥ 2.
- REPEAT_EN, 1: 1 enables auto-repeat while held; 0 gives one pulse per press.
- REPEAT_DELAY, 25000000: cycles from accepted press to first repeat pulse; ≥ 2.
- REPEAT_PERIOD, 5000000: cycles between subsequent repeat pulses; ≥ 2.
- CNT_W, 25: counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) − 1.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- button  input  1  raw push-button, asynchronous, active-high.
- step  output  1  one-cycle pulse per accepted press and per repeat.
- level  output  1  debounced button level.
- repeating  output  1  high while in the REPEAT state.

## Operation

- Synchroniser: two flops `s1 → s2`. Both reset to 0. `s2` is the sampled button.
- Debounce, with counter `dcnt`:
  - `s2 == level`: `dcnt <= 0`.
  - Otherwise, if `dcnt == DEBOUNCE_CYCLES-1`: `level <= ~level`, `dcnt <= 0`.
  - Otherwise: `dcnt <= dcnt+1`.
  - Any glitch shorter than the window restarts the count, and `level` does not change.
- FSM states: RELEASED, HOLD_WAIT, REPEAT. Hold counter `hcnt`.
  - RELEASED: on the edge where `level` rises, `step <= 1`, `hcnt <= 0`. Go to HOLD_WAIT if REPEAT_EN, otherwise go to REPEAT with counting frozen.
  - HOLD_WAIT: `hcnt` increments. At `hcnt == REPEAT_DELAY-1`: pulse `step`, `hcnt <= 0`, go to REPEAT.
  - REPEAT: `hcnt` increments. At `hcnt == REPEAT_PERIOD-1`: pulse `step`, `hcnt <= 0`. When REPEAT_EN = 0, no pulses.
  - From any state, when `level` falls: go to RELEASED, `hcnt <= 0`, no pulse. The fall has priority over a coincident repeat pulse.
- `step` is registered and is high for exactly one cycle per event.
- `repeating` = (state == REPEAT) && REPEAT_EN.
- Reset values: `s1`, `s2`, `level`, `step`, `repeating`, `dcnt`, `hcnt` = 0; state = RELEASED.
- Reset mid-operation: all state is cleared. A button still held after reset is treated as a new press once debounced.

## Timing

- Edge numbering: edge 0 is the first clk edge at which `button` = 1 is sampled into `s1`.
- Press latency: `level` and `step` rise after edge DEBOUNCE_CYCLES+1. `step` falls after the next edge.
- Release latency: `level` falls after the same number of edges, DEBOUNCE_CYCLES+1, counted from the first edge sampling `button` = 0.
- Repeat pulses, held continuously: the first press pulse lands at edge P = DEBOUNCE_CYCLES+1. Repeat pulses follow at P+REPEAT_DELAY, then every REPEAT_PERIOD edges after that.
- Counters wrap only through explicit clears and never overflow within the parameter constraints.
- Minimum accepted press or release width is DEBOUNCE_CYCLES cycles of stable sampled level.

## Structure

- Shared package `frog_io_pkg` holds:
  - the FSM state typedef (RELEASED, HOLD_WAIT, REPEAT);
  - the default timing constants (debounce, delay, period at 50 MHz);
  - the simulation defaults used by the bench.
- One sub-module, `debounce_filter`. It contains the synchroniser plus the `dcnt` logic, takes `clk`, `rst`, `button`, and outputs `level` and a one-cycle `rise` strobe. The top contains only the FSM, `hcnt`, and `step`.

## Test plan

Simulation parameters: DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 10, REPEAT_PERIOD = 3, REPEAT_EN = 1.

- Reset: assert `rst` for 3 cycles with `button` = 1 → `step`, `level`, `repeating` all 0 throughout. After release of reset, the press is detected as new, with `step` after edge 5 measured from the first non-reset edge.
- Clean hold: `button` = 1 from edge 0 onward → `step` pulses after edges 5, 15, 18, 21. `repeating` rises after edge 15. Each pulse is exactly one cycle wide.
- Bounce: `button` toggles every 2 cycles for 20 cycles, then stays 0 → `level` and `step` stay 0 throughout.
- Release: hold until edge 16, then `button` = 0 → `level` falls after edge 21 (16+5). No `step` pulse occurs after edge 18. State returns to RELEASED and `repeating` = 0.
- No repeat: REPEAT_EN = 0, `button` held for 50 cycles → exactly one `step`, after edge 5.
- Reset mid-hold: `rst` pulsed for one cycle at edge 12 while held → outputs cleared at edge 13. Next `step` follows five edges after reset deasserts.
